// File: rtl/pixel_pkg.sv
// Shared constants and state encoding for the window fetch sequencer and its window buffer.
package pixel_pkg;

    localparam int PIXEL_W    = 8;
    localparam int WIN_PIXELS = 9;
    localparam int ADDR_W     = 32;
    localparam int WIN_W      = PIXEL_W * WIN_PIXELS;
    localparam int SLOT_W     = 4;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        REQ_R      = 4'd1,
        WAIT_RADDR = 4'd2,
        MEM_RD     = 4'd3,
        REQ_W      = 4'd4,
        WAIT_WADDR = 4'd5,
        MEM_WR     = 4'd6,
        COMPUTE    = 4'd7,
        FINISH     = 4'd8
    } seq_state_t;

endpackage

// File: rtl/window_buffer.sv
// 3x3 pixel window storage: one slot written per read, flattened with slot k at bits [8k+7:8k].
module window_buffer
    import pixel_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [SLOT_W-1:0]  wr_idx,
    input  logic [PIXEL_W-1:0] wr_data,
    output logic [WIN_W-1:0]   window
);

    logic [PIXEL_W-1:0] pix [WIN_PIXELS];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int k = 0; k < WIN_PIXELS; k++) begin
                pix[k] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < WIN_PIXELS; k++) begin
                if (wr_idx == SLOT_W'(k)) begin
                    pix[k] <= wr_data;
                end
            end
        end
    end

    for (genvar k = 0; k < WIN_PIXELS; k++) begin : g_flat
        assign window[k*PIXEL_W +: PIXEL_W] = pix[k];
    end

endmodule

// File: rtl/window_fetch_sequencer.sv
// Drives the address counter, fetches nine pixels per window from memory, hands the window to
// the filter and writes each filter result back, until the counter flags the last write.
module window_fetch_sequencer
    import pixel_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_stop,
    output logic               o_inc_raddr,
    output logic               o_inc_waddr,
    input  logic               i_r_ready,
    input  logic               i_w_ready,
    input  logic [ADDR_W-1:0]  i_raddr,
    input  logic [ADDR_W-1:0]  i_waddr,
    input  logic               i_done,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic [ADDR_W-1:0]  o_mem_addr,
    output logic [PIXEL_W-1:0] o_mem_wdata,
    input  logic [PIXEL_W-1:0] i_mem_rdata,
    input  logic               i_mem_rvalid,
    input  logic               i_mem_wack,
    output logic [WIN_W-1:0]   o_window,
    output logic               o_window_valid,
    input  logic [PIXEL_W-1:0] i_result,
    input  logic               i_result_valid,
    output logic               o_frame_done,
    output logic [31:0]        o_pix_count,
    output seq_state_t         dbg_state
);

    // Handshakes: each request (inc pulse or held memory strobe) stays alone until its answer
    // (ready, rvalid, wack, result_valid) is seen in the matching wait state; answers arriving
    // in any other state are dropped, and an answer in the same cycle as the request is taken.

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WIN_PIXELS - 1);

    seq_state_t         state, next_state;
    logic [SLOT_W-1:0]  slot;
    logic               done_latch;
    logic               window_valid;
    logic [ADDR_W-1:0]  mem_addr;
    logic [PIXEL_W-1:0] wdata;
    logic [31:0]        pix_count;

    logic frame_start, raddr_take, slot_wr, result_take, waddr_take, write_done;

    always_comb begin
        next_state  = state;
        frame_start = 1'b0;
        raddr_take  = 1'b0;
        slot_wr     = 1'b0;
        result_take = 1'b0;
        waddr_take  = 1'b0;
        write_done  = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    frame_start = 1'b1;
                    next_state  = REQ_R;
                end
            end
            REQ_R:      next_state = WAIT_RADDR;
            WAIT_RADDR: begin
                if (i_r_ready) begin
                    raddr_take = 1'b1;
                    next_state = MEM_RD;
                end
            end
            MEM_RD: begin
                if (i_mem_rvalid) begin
                    slot_wr    = 1'b1;
                    next_state = (slot == LAST_SLOT) ? COMPUTE : REQ_R;
                end
            end
            COMPUTE: begin
                if (i_result_valid) begin
                    result_take = 1'b1;
                    next_state  = REQ_W;
                end
            end
            REQ_W:      next_state = WAIT_WADDR;
            WAIT_WADDR: begin
                if (i_w_ready) begin
                    waddr_take = 1'b1;
                    next_state = MEM_WR;
                end
            end
            MEM_WR: begin
                if (i_mem_wack) begin
                    write_done = 1'b1;
                    next_state = done_latch ? FINISH : REQ_R;
                end
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            slot         <= '0;
            done_latch   <= 1'b0;
            window_valid <= 1'b0;
            mem_addr     <= '0;
            wdata        <= '0;
            pix_count    <= '0;
        end else begin
            state        <= next_state;
            window_valid <= slot_wr && (slot == LAST_SLOT);
            if (frame_start) begin
                slot       <= '0;
                done_latch <= 1'b0;
                pix_count  <= '0;
            end
            if (raddr_take) begin
                mem_addr <= i_raddr;
            end
            if (slot_wr) begin
                slot <= slot + 1'b1;
            end
            if (result_take) begin
                wdata <= i_result;
            end
            if (waddr_take) begin
                mem_addr   <= i_waddr;
                done_latch <= i_done;
            end
            // The slot counter restarts for the next window once its result is stored.
            if (write_done) begin
                pix_count <= pix_count + 32'd1;
                slot      <= '0;
            end
        end
    end

    window_buffer u_window_buffer (
        .clk     (clk),
        .rst     (rst),
        .clear   (frame_start),
        .wr_en   (slot_wr),
        .wr_idx  (slot),
        .wr_data (i_mem_rdata),
        .window  (o_window)
    );

    assign o_busy         = (state != IDLE);
    assign o_stop         = (state == IDLE);
    assign o_inc_raddr    = (state == REQ_R);
    assign o_inc_waddr    = (state == REQ_W);
    assign o_mem_read     = (state == MEM_RD);
    assign o_mem_write    = (state == MEM_WR);
    assign o_frame_done   = (state == FINISH);
    assign o_window_valid = window_valid;
    assign o_mem_addr     = mem_addr;
    assign o_mem_wdata    = wdata;
    assign o_pix_count    = pix_count;
    assign dbg_state      = state;

endmodule

// File: tb/tb_window_fetch_sequencer.sv
// Directed bench: address-counter, memory and filter models answer the sequencer with set latencies.
module tb_window_fetch_sequencer;
    import pixel_pkg::*;

    localparam logic [WIN_W-1:0] WIN_100 = 72'h6C6B6A696867666564;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               i_start = 1'b0;
    logic               o_busy, o_stop, o_inc_raddr, o_inc_waddr;
    logic               i_r_ready, i_w_ready, i_done;
    logic [ADDR_W-1:0]  i_raddr, i_waddr;
    logic               o_mem_read, o_mem_write;
    logic [ADDR_W-1:0]  o_mem_addr;
    logic [PIXEL_W-1:0] o_mem_wdata;
    logic [PIXEL_W-1:0] i_mem_rdata;
    logic               i_mem_rvalid, i_mem_wack;
    logic [WIN_W-1:0]   o_window;
    logic               o_window_valid;
    logic [PIXEL_W-1:0] i_result;
    logic               i_result_valid;
    logic               o_frame_done;
    logic [31:0]        o_pix_count;
    seq_state_t         dbg_state;

    window_fetch_sequencer dut (
        .clk(clk), .rst(rst), .i_start(i_start), .o_busy(o_busy), .o_stop(o_stop),
        .o_inc_raddr(o_inc_raddr), .o_inc_waddr(o_inc_waddr),
        .i_r_ready(i_r_ready), .i_w_ready(i_w_ready), .i_raddr(i_raddr), .i_waddr(i_waddr),
        .i_done(i_done), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_wack(i_mem_wack), .o_window(o_window),
        .o_window_valid(o_window_valid), .i_result(i_result), .i_result_valid(i_result_valid),
        .o_frame_done(o_frame_done), .o_pix_count(o_pix_count), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_bad    = 0;
    logic [PIXEL_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- event counters ----------------
    int n_inc_r = 0, n_rv = 0, n_wv = 0, n_fd = 0;
    always @(posedge clk) begin
        if (o_inc_raddr) n_inc_r++;
        if (o_mem_read && i_mem_rvalid) n_rv++;
        if (o_window_valid) n_wv++;
        if (o_frame_done) n_fd++;
    end

    // ---------------- responder models ----------------
    int r_lat = 4, w_lat = 2, rd_lat = 1, wack_lat = 2, f_lat = 2, done_after = 4;
    logic spur_r = 1'b0, spur_f = 1'b0;
    int r_cnt, w_cnt, rd_cnt, wr_cnt, f_cnt, w_num;
    logic r_pend, w_pend, rd_pend, wr_pend, f_pend, rd_prev, wr_prev;
    logic [ADDR_W-1:0] raddr_next, last_raddr, last_waddr;
    logic [PIXEL_W-1:0] res_next = 8'h5A;

    task automatic answer_read();
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = o_mem_addr[7:0];
    endtask

    task automatic answer_write();
        i_mem_wack = 1'b1;
        check("wr_addr", o_mem_addr, last_waddr);
        if (exp_q.size() == 0) begin
            check("wr_unexpected", o_mem_write, 1'b0);
        end else begin
            check("wr_data", o_mem_wdata, exp_q.pop_front());
        end
    endtask

    task automatic answer_filter();
        i_result_valid = 1'b1;
        i_result       = res_next;
        exp_q.push_back(res_next);
        res_next++;
    endtask

    initial begin
        i_r_ready = 0; i_w_ready = 0; i_done = 0; i_raddr = '0; i_waddr = '0;
        i_mem_rvalid = 0; i_mem_wack = 0; i_mem_rdata = '0; i_result_valid = 0; i_result = '0;
        r_pend = 0; w_pend = 0; rd_pend = 0; wr_pend = 0; f_pend = 0; rd_prev = 0; wr_prev = 0;
        raddr_next = 100; last_raddr = 0; last_waddr = 0; w_num = 0;
        forever begin
            @(negedge clk);
            i_r_ready = 0; i_w_ready = 0; i_done = 0;
            i_mem_rvalid = 0; i_mem_wack = 0; i_result_valid = 0;
            if (o_stop) begin
                r_pend = 0; w_pend = 0; rd_pend = 0; wr_pend = 0; f_pend = 0;
                rd_prev = 0; wr_prev = 0; raddr_next = 100; w_num = 0;
            end else begin
                if (r_pend) begin
                    if (r_cnt <= 1) begin
                        r_pend = 0; i_r_ready = 1; i_raddr = raddr_next;
                        last_raddr = raddr_next; raddr_next++;
                    end else r_cnt--;
                end else if (o_inc_raddr) begin
                    r_pend = 1; r_cnt = r_lat;
                end
                if (w_pend) begin
                    if (w_cnt <= 1) begin
                        w_pend = 0; w_num++; i_w_ready = 1;
                        i_waddr = 32'(2000 + w_num - 1); last_waddr = i_waddr;
                        i_done = (w_num == done_after);
                    end else w_cnt--;
                end else if (o_inc_waddr) begin
                    w_pend = 1; w_cnt = w_lat;
                end
                if (rd_pend) begin
                    if (rd_cnt <= 1) begin rd_pend = 0; answer_read(); end else rd_cnt--;
                end else if (o_mem_read && !rd_prev) begin
                    if (rd_lat == 0) answer_read(); else begin rd_pend = 1; rd_cnt = rd_lat; end
                end
                if (wr_pend) begin
                    if (wr_cnt <= 1) begin wr_pend = 0; answer_write(); end else wr_cnt--;
                end else if (o_mem_write && !wr_prev) begin
                    if (wack_lat == 0) answer_write(); else begin wr_pend = 1; wr_cnt = wack_lat; end
                end
                if (f_pend) begin
                    if (f_cnt <= 1) begin f_pend = 0; answer_filter(); end else f_cnt--;
                end else if (o_window_valid) begin
                    if (f_lat == 0) answer_filter(); else begin f_pend = 1; f_cnt = f_lat; end
                end
                // Stray answers that the sequencer must drop.
                if (spur_r && o_mem_read) begin
                    check("rd_addr_hold", o_mem_addr, last_raddr);
                    if (!i_mem_rvalid) begin i_r_ready = 1; i_raddr = 32'hDEAD_BEEF; end
                end
                if (spur_f && dbg_state == WAIT_RADDR) begin
                    i_result_valid = 1; i_result = 8'hEE;
                end
                rd_prev = o_mem_read;
                wr_prev = o_mem_write;
            end
        end
    end

    // ---------------- driver tasks ----------------
    int base_inc, base_rv, base_wv, base_fd;

    function automatic logic sig(input int sel);
        case (sel)
            0:       return o_window_valid;
            1:       return o_mem_write;
            2:       return o_frame_done;
            default: return o_mem_read && (n_inc_r - base_inc == 15);
        endcase
    endfunction

    task automatic wait_for(input int sel, input string tag);
        int n = 0;
        while (!sig(sel) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, sig(sel), 1'b1);
    endtask

    task automatic start_frame();
        base_inc = n_inc_r; base_rv = n_rv; base_wv = n_wv; base_fd = n_fd;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_stop", o_stop, 1'b1);
        check("rst_state", dbg_state, IDLE);
        check("rst_strobes", {o_busy, o_inc_raddr, o_inc_waddr, o_mem_read, o_mem_write,
                              o_window_valid, o_frame_done}, '0);
        check("rst_window", o_window, '0);
        check("rst_addr", o_mem_addr, '0);
        check("rst_pix", o_pix_count, '0);

        // Frame 1: counter latency 4, memory 1, four windows.
        start_frame();
        wait_for(0, "t1_wv_timeout");
        check("t1_window", o_window, WIN_100);
        check("t1_inc_r", n_inc_r - base_inc, 9);
        wait_for(1, "t2_wr_timeout");
        check("t2_addr", o_mem_addr, 2000);
        check("t2_wdata", o_mem_wdata, 8'h5A);
        cnt = 0;
        while (o_mem_write && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("t2_wr_cycles", cnt, 3);
        check("t2_pix", o_pix_count, 1);
        check("t2_next_state", dbg_state, REQ_R);
        check("t1_wv_once", n_wv - base_wv, 1);
        wait_for(2, "t3_fd_timeout");
        check("t3_pix", o_pix_count, 4);
        @(negedge clk);
        check("t3_fd_once", n_fd - base_fd, 1);
        check("t3_idle", dbg_state, IDLE);
        check("t3_stop", {o_stop, o_busy}, 2'b10);

        // Frame 2: stray ready and result_valid in the wrong states.
        rd_lat = 3; spur_r = 1'b1; spur_f = 1'b1;
        start_frame();
        wait_for(0, "t4_wv_timeout");
        check("t4_window", o_window, WIN_100);
        check("t4_inc_r", n_inc_r - base_inc, 9);
        check("t4_rv", n_rv - base_rv, 9);
        wait_for(2, "t4_fd_timeout");
        check("t4_pix", o_pix_count, 4);
        spur_r = 1'b0; spur_f = 1'b0; rd_lat = 1;
        @(negedge clk);

        // Frame 3: reset during the slot-5 read of the second window.
        start_frame();
        wait_for(3, "t5_slot5_timeout");
        check("t5_pre_state", dbg_state, MEM_RD);
        check("t5_pre_pix", o_pix_count, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("t5_state", dbg_state, IDLE);
        check("t5_strobes", {o_stop, o_mem_read, o_busy}, 3'b100);
        check("t5_window", o_window, '0);
        check("t5_pix", o_pix_count, 0);
        check("t5_addr", o_mem_addr, 0);
        done_after = 1;
        @(negedge clk);
        start_frame();
        wait_for(0, "t5_wv_timeout");
        check("t5_window_restart", o_window, WIN_100);
        check("t5_inc_r", n_inc_r - base_inc, 9);
        wait_for(2, "t5_fd_timeout");
        check("t5_pix_end", o_pix_count, 1);
        @(negedge clk);

        // Frame 4: zero-latency memory and filter, counter latency 1.
        r_lat = 1; rd_lat = 0; f_lat = 0; w_lat = 1; wack_lat = 0;
        start_frame();
        cnt = 0;
        while (!o_window_valid && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        check("t6_cycles_to_window", cnt, 27);
        check("t6_window", o_window, WIN_100);
        check("t6_rv", n_rv - base_rv, 9);
        wait_for(2, "t6_fd_timeout");
        check("t6_pix", o_pix_count, 1);
        @(negedge clk);
        check("t6_wv_once", n_wv - base_wv, 1);
        check("t6_idle", dbg_state, IDLE);
        check("exp_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
